// File: rtl/dmem_responder_if.sv
// Data-memory port between the CPU core (master) and the data-memory responder (slave).
// ReadData is combinational in Addr/Funct3, so a load completes in the issuing cycle.
interface dmem_responder_if;
    logic        MemWrite;
    logic        MemRead;
    logic [2:0]  Funct3;
    logic [31:0] Addr;
    logic [31:0] WrData;
    logic [31:0] ReadData;

    modport master (
        output MemWrite, MemRead, Funct3, Addr, WrData,
        input  ReadData
    );

    modport slave (
        input  MemWrite, MemRead, Funct3, Addr, WrData,
        output ReadData
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM with byte/half/word lanes plus an MMIO window
// (GPIO, 64-bit cycle counter with hi snapshot, RAM-store counter). Optional DMEM_MISALIGN_TRAP_EN.
module dmem_responder #(
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000,
    parameter int          GPIO_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    dmem_responder_if.slave   bus,
    output logic [GPIO_W-1:0] gpio_out
);
    localparam int AW = $clog2(DEPTH);

    localparam logic [13:0] OFF_GPIO   = 14'h0;
    localparam logic [13:0] OFF_CYC_LO = 14'h1;
    localparam logic [13:0] OFF_CYC_HI = 14'h2;
    localparam logic [13:0] OFF_ST_CNT = 14'h3;
    localparam logic [13:0] OFF_ERR    = 14'h4;

    logic [31:0]   mem [DEPTH];
    logic [63:0]   cycle_cnt;
    logic [31:0]   hi_snap;
    logic [31:0]   store_cnt;

    logic          is_mmio;
    logic [13:0]   off;
    logic [AW-1:0] idx;
    logic          st_f3_ok;
    logic          ram_we;
    logic          mis_st;
    logic          mis_ld;
    logic [3:0]    st_be;
    logic [31:0]   st_data;
    logic [31:0]   word;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic [31:0]   rd_ram;
    logic [31:0]   rd_mmio;

    assign is_mmio  = (bus.Addr[31:16] == MMIO_BASE[31:16]);
    assign off      = bus.Addr[15:2];
    assign idx      = bus.Addr[AW+1:2];
    assign st_f3_ok = (bus.Funct3 == 3'b000) || (bus.Funct3 == 3'b001) || (bus.Funct3 == 3'b010);

`ifdef DMEM_MISALIGN_TRAP_EN
    logic err_sticky;

    assign mis_st = ((bus.Funct3 == 3'b001) && bus.Addr[0]) ||
                    ((bus.Funct3 == 3'b010) && (bus.Addr[1:0] != 2'b00));
    assign mis_ld = ((bus.Funct3[1:0] == 2'b01) && bus.Addr[0]) ||
                    ((bus.Funct3 == 3'b010) && (bus.Addr[1:0] != 2'b00));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_sticky <= 1'b0;
        end else if (bus.MemWrite && is_mmio && (off == OFF_ERR)) begin
            err_sticky <= 1'b0;
        end else if (bus.MemWrite && !is_mmio && mis_st) begin
            err_sticky <= 1'b1;
        end
    end
`else
    assign mis_st = 1'b0;
    assign mis_ld = 1'b0;
`endif

    assign ram_we = bus.MemWrite && !is_mmio && st_f3_ok && !mis_st;

    // Store data is replicated across lanes so the byte enables alone pick the target lane.
    always_comb begin
        st_be   = 4'b0000;
        st_data = bus.WrData;
        case (bus.Funct3)
            3'b000: begin
                st_be   = 4'b0001 << bus.Addr[1:0];
                st_data = {4{bus.WrData[7:0]}};
            end
            3'b001: begin
                st_be   = bus.Addr[1] ? 4'b1100 : 4'b0011;
                st_data = {2{bus.WrData[15:0]}};
            end
            3'b010:  st_be = 4'b1111;
            default: st_be = 4'b0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (st_be[i]) mem[idx][8*i +: 8] <= st_data[8*i +: 8];
            end
        end
    end

    always_comb begin
        word = mem[idx];
        case (bus.Addr[1:0])
            2'b00:   ld_byte = word[7:0];
            2'b01:   ld_byte = word[15:8];
            2'b10:   ld_byte = word[23:16];
            default: ld_byte = word[31:24];
        endcase
        ld_half = bus.Addr[1] ? word[31:16] : word[15:0];
        case (bus.Funct3)
            3'b000:  rd_ram = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  rd_ram = {{16{ld_half[15]}}, ld_half};
            3'b010:  rd_ram = word;
            3'b100:  rd_ram = {24'd0, ld_byte};
            3'b101:  rd_ram = {16'd0, ld_half};
            default: rd_ram = 32'd0;
        endcase
        if (mis_ld) rd_ram = 32'd0;
    end

    always_comb begin
        rd_mmio = 32'd0;
        case (off)
            OFF_GPIO:   rd_mmio = 32'(gpio_out);
            OFF_CYC_LO: rd_mmio = cycle_cnt[31:0];
            OFF_CYC_HI: rd_mmio = hi_snap;
            OFF_ST_CNT: rd_mmio = store_cnt;
`ifdef DMEM_MISALIGN_TRAP_EN
            OFF_ERR:    rd_mmio = {31'd0, err_sticky};
`endif
            default:    rd_mmio = 32'd0;
        endcase
    end

    assign bus.ReadData = is_mmio ? rd_mmio : rd_ram;

    // Snapshot takes the pre-increment high word, so it pairs with the low word read this cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_cnt <= 64'd0;
            hi_snap   <= 32'd0;
        end else begin
            cycle_cnt <= cycle_cnt + 64'd1;
            if (bus.MemRead && is_mmio && (off == OFF_CYC_LO)) hi_snap <= cycle_cnt[63:32];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gpio_out  <= '0;
            store_cnt <= 32'd0;
        end else begin
            if (bus.MemWrite && is_mmio && (off == OFF_GPIO)) gpio_out <= bus.WrData[GPIO_W-1:0];
            if (bus.MemWrite && is_mmio && (off == OFF_ST_CNT)) begin
                store_cnt <= 32'd0;
            end else if (ram_we && (store_cnt != 32'hFFFF_FFFF)) begin
                store_cnt <= store_cnt + 32'd1;
            end
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: expected load data queued at issue and popped at sample time.
module tb_dmem_responder;
    localparam int          DEPTH  = 1024;
    localparam logic [31:0] BASE   = 32'hFFFF_0000;
    localparam logic [31:0] GPIO   = BASE + 32'h00;
    localparam logic [31:0] CYC_LO = BASE + 32'h04;
    localparam logic [31:0] CYC_HI = BASE + 32'h08;
    localparam logic [31:0] ST_CNT = BASE + 32'h0C;
    localparam logic [31:0] ERR    = BASE + 32'h10;
    localparam logic [2:0]  F_B  = 3'b000, F_H = 3'b001, F_W = 3'b010,
                            F_BU = 3'b100, F_HU = 3'b101, F_BAD = 3'b011;

    logic       clk;
    logic       rst_n;
    logic [7:0] gpio;
    int         errors;
    int         checks;
    logic [31:0] exp_q[$];
    logic [31:0] lo_a;
    logic [31:0] lo_b;

    dmem_responder_if bus();

    dmem_responder #(.DEPTH(DEPTH), .MMIO_BASE(BASE), .GPIO_W(8)) dut (
        .clk      (clk),
        .reset    (rst_n),
        .bus      (bus),
        .gpio_out (gpio)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Issue a load in the current cycle and compare after combinational settle.
    task automatic load_now(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] expv,
                            input string tag);
        logic [31:0] e;
        bus.MemWrite = 1'b0;
        bus.MemRead  = 1'b1;
        bus.Funct3   = f3;
        bus.Addr     = a;
        exp_q.push_back(expv);
        #1;
        e = exp_q.pop_front();
        check(tag, bus.ReadData, e);
    endtask

    task automatic load(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] expv,
                        input string tag);
        @(negedge clk);
        load_now(a, f3, expv, tag);
    endtask

    task automatic store(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] d);
        @(negedge clk);
        bus.MemWrite = 1'b1;
        bus.MemRead  = 1'b0;
        bus.Funct3   = f3;
        bus.Addr     = a;
        bus.WrData   = d;
        @(posedge clk);
        #1 bus.MemWrite = 1'b0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n = 1'b0;
        bus.MemWrite = 1'b0;
        bus.MemRead  = 1'b0;
        bus.Funct3   = F_W;
        bus.Addr     = 32'd0;
        bus.WrData   = 32'd0;
        repeat (3) @(posedge clk);

        @(negedge clk);
        rst_n = 1'b1;
        load_now(CYC_LO, F_W, 32'd0, "cyc_lo_first");
        check("gpio_reset", 32'(gpio), 32'd0);
        load(ST_CNT, F_W, 32'd0, "stcnt_reset");
        load(CYC_HI, F_W, 32'd0, "cyc_hi_reset");

        store(32'h10, F_W, 32'h8000_00FF);
        load(32'h10, F_B,  32'hFFFF_FFFF, "lb_10");
        load(32'h13, F_BU, 32'h0000_0080, "lbu_13");
        load(32'h12, F_H,  32'hFFFF_8000, "lh_12");
        load(32'h12, F_HU, 32'h0000_8000, "lhu_12");
        load(32'h10, F_W,  32'h8000_00FF, "lw_10");
        load(ST_CNT, F_W,  32'd1, "stcnt_1");

        store(32'h20, F_W, 32'h1122_3344);
        store(32'h21, F_B, 32'h0000_00AA);
        store(32'h22, F_H, 32'h0000_BEEF);
        load(32'h20, F_W, 32'hBEEF_AA44, "lw_lanes");
        load(32'h21, F_B, 32'hFFFF_FFAA, "lb_21");
        load(32'h20, F_H, 32'hFFFF_AA44, "lh_20");
        load(ST_CNT, F_W, 32'd4, "stcnt_4");

        store(32'h20, F_BAD, 32'h0000_0000);
        load(32'h20, F_W,   32'hBEEF_AA44, "bad_f3_store");
        load(32'h20, F_BAD, 32'h0000_0000, "bad_f3_load");
        load(ST_CNT, F_W,   32'd4, "stcnt_bad_f3");

        store(DEPTH * 4 + 32'h4, F_W, 32'hCAFE_F00D);
        load(32'h4, F_W, 32'hCAFE_F00D, "wrap");
        load(ST_CNT, F_W, 32'd5, "stcnt_5");

        store(GPIO, F_W, 32'h1234_56A5);
        @(negedge clk);
        check("gpio_out", 32'(gpio), 32'h0000_00A5);
        load(GPIO, F_W, 32'h0000_00A5, "gpio_read");
        load(ST_CNT, F_W, 32'd5, "stcnt_mmio_nocount");
        load(BASE + 32'h40, F_W, 32'd0, "unmapped");
        store(ST_CNT, F_W, 32'hFFFF_FFFF);
        load(ST_CNT, F_W, 32'd0, "stcnt_clear");

        @(negedge clk);
        bus.MemRead = 1'b0;
        bus.Addr    = CYC_LO;
        #1 lo_a = bus.ReadData;
        repeat (10) @(posedge clk);
        @(negedge clk);
        #1 lo_b = bus.ReadData;
        check("cycle_delta", lo_b - lo_a, 32'd10);

        @(negedge clk);
        force dut.cycle_cnt = 64'h0000_0000_FFFF_FFFF;
        #1 release dut.cycle_cnt;
        load_now(CYC_LO, F_W, 32'hFFFF_FFFF, "cyc_lo_wrap");
        load(CYC_HI, F_W, 32'd0, "cyc_hi_snap_pre");
        load(CYC_LO, F_W, 32'd1, "cyc_lo_after");
        load(CYC_HI, F_W, 32'd1, "cyc_hi_snap_post");

`ifdef DMEM_MISALIGN_TRAP_EN
        store(32'h22, F_W, 32'h5555_6666);
        load(32'h20, F_W, 32'hBEEF_AA44, "mis_ram_unchanged");
        load(ERR, F_W, 32'd1, "mis_err_set");
        load(ST_CNT, F_W, 32'd0, "mis_nocount");
        load(32'h22, F_W, 32'd0, "mis_load_zero");
        store(ERR, F_W, 32'd0);
        load(ERR, F_W, 32'd0, "mis_err_clear");
`else
        load(ERR, F_W, 32'd0, "err_reads_zero");
        store(32'h22, F_W, 32'h5555_6666);
        load(32'h20, F_W, 32'h5555_6666, "mask_sw");
        load(ST_CNT, F_W, 32'd1, "mask_count");
`endif

        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("gpio_async_reset", 32'(gpio), 32'd0);
        load_now(ST_CNT, F_W, 32'd0, "stcnt_async_reset");
        load_now(CYC_LO, F_W, 32'd0, "cyc_async_reset");
        rst_n = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
